// File: rtl/dac_pkg.sv
// dac_pkg: shared types and constants for the 12-bit DAC SPI writer.
// Holds the FSM state encoding, frame geometry, DAC power-down field
// encodings and the helper that assembles a 16-bit DAC frame.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } dac_state_e;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  // Frame layout, MSB first: two zero bits, power-down field, sample.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [1:0]           pd,
    input logic [DATA_BITS-1:0] data
  );
    return {2'b00, pd, data};
  endfunction

endpackage

// File: rtl/dac_write_12bit_sck_gen.sv
// dac_sck_gen: SCK generator for the DAC writer.
// While enabled, SCK toggles every CLK_DIV clk cycles; the cycle before each
// toggle raises a one-cycle sck_fall_o / sck_rise_o strobe so the FSM can act
// on the same edge SCK changes. When disabled, SCK is held high and the
// half-period counter is reloaded, so every frame starts from a clean phase.
module dac_sck_gen
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sck_o,
  output logic sck_fall_o,
  output logic sck_rise_o
);

  localparam int            HW     = $clog2(CLK_DIV + 1);
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          sck_q, sck_d;
  logic          tick_s;

  assign tick_s     = en_i && (hcnt_q == H_LAST);
  assign sck_fall_o = tick_s && sck_q;
  assign sck_rise_o = tick_s && !sck_q;
  assign sck_o      = sck_q;

  // Next half-period count and SCK level; idle forces SCK high and reloads.
  always_comb begin
    hcnt_d = hcnt_q;
    sck_d  = sck_q;
    if (!en_i) begin
      hcnt_d = {HW{1'b0}};
      sck_d  = 1'b1;
    end else if (tick_s) begin
      hcnt_d = {HW{1'b0}};
      sck_d  = !sck_q;
    end else begin
      hcnt_d = hcnt_q + HW'(1'b1);
    end
  end

  // Half-period counter and SCK register; reset leaves SCK idling high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q <= {HW{1'b0}};
      sck_q  <= 1'b1;
    end else begin
      hcnt_q <= hcnt_d;
      sck_q  <= sck_d;
    end
  end

endmodule

// File: rtl/dac_write_12bit.sv
// dac_write_12bit: SPI master feeding 12-bit samples to an external DAC.
// Words enter a one-entry holding register over valid/ready and are sent as
// 16-bit frames (00, pd, data) on CS/SCK/SDI. The holding register refills
// while a frame shifts, so back-to-back frames are separated only by the
// CS_GAP high time.
// Optional feature macro: DAC_PD_CTRL_EN adds the pd_mode port whose value is
// captured with each word and sent in frame bits 13:12; without it those
// bits are 00 (normal operation).
module dac_write_12bit
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
`ifdef DAC_PD_CTRL_EN
  input  logic [1:0]  pd_mode,
`endif
  output logic        CS,
  output logic        SCK,
  output logic        SDI,
  output logic        busy,
  output logic        frame_done
);

  // The IDLE cycle between GAP and the next SHIFT also keeps CS high, so the
  // GAP state itself lasts CS_GAP-1 cycles (at least one).
  localparam int            GW       = $clog2(CS_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((CS_GAP > 1) ? (CS_GAP - 2) : 0);
  localparam logic [4:0]    LAST_BIT = 5'(FRAME_BITS);

  dac_state_e state_q, state_d;

  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  sdi_q, sdi_d;
  logic                  cs_q, cs_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  hold_empty_q, hold_empty_d;
  logic [DATA_BITS-1:0]  hold_data_q, hold_data_d;

  logic                  accept_s;
  logic                  load_s;
  logic                  sck_en_s;
  logic                  sck_s;
  logic                  sck_fall_s;
  logic                  sck_rise_s;
  logic [1:0]            frame_pd_s;
  logic [FRAME_BITS-1:0] frame_s;

  assign accept_s = data_valid && hold_empty_q;
  assign sck_en_s = (state_q == SHIFT);
  assign frame_s  = build_frame(frame_pd_s, hold_data_q);

  assign data_ready = hold_empty_q;
  assign CS         = cs_q;
  assign SCK        = sck_s;
  assign SDI        = sdi_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  dac_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .rst       (rst),
    .en_i      (sck_en_s),
    .sck_o     (sck_s),
    .sck_fall_o(sck_fall_s),
    .sck_rise_o(sck_rise_s)
  );

`ifdef DAC_PD_CTRL_EN
  logic [1:0] hold_pd_q, hold_pd_d;

  assign frame_pd_s = hold_pd_q;

  // Power-down field travels with the sample through the holding register.
  always_comb begin
    hold_pd_d = hold_pd_q;
    if (accept_s) begin
      hold_pd_d = pd_mode;
    end else if (load_s) begin
      hold_pd_d = PD_NORMAL;
    end else begin
      hold_pd_d = hold_pd_q;
    end
  end

  // Power-down field register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_pd_q <= PD_NORMAL;
    end else begin
      hold_pd_q <= hold_pd_d;
    end
  end
`else
  assign frame_pd_s = PD_NORMAL;
`endif

  // Holding register: fill on accept, empty when the FSM takes the word.
  // Accept needs empty and load needs full, so the two never coincide.
  always_comb begin
    hold_empty_d = hold_empty_q;
    hold_data_d  = hold_data_q;
    if (accept_s) begin
      hold_empty_d = 1'b0;
      hold_data_d  = data_in;
    end else if (load_s) begin
      hold_empty_d = 1'b1;
      hold_data_d  = {DATA_BITS{1'b0}};
    end else begin
      hold_empty_d = hold_empty_q;
    end
  end

  // Frame FSM: start a frame from a full holding register, shift on SCK
  // strobes, close the frame on the rise after the 16th fall, then hold CS
  // high for the gap.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shift_d   = shift_q;
    sdi_d     = sdi_q;
    cs_d      = cs_q;
    done_d    = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      IDLE: begin
        cs_d  = 1'b1;
        sdi_d = 1'b0;
        if (!hold_empty_q) begin
          state_d   = SHIFT;
          shift_d   = frame_s;
          sdi_d     = frame_s[FRAME_BITS-1];
          cs_d      = 1'b0;
          bit_cnt_d = 5'd0;
          load_s    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (sck_fall_s) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end else if (sck_rise_s) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = GAP;
            cs_d      = 1'b1;
            sdi_d     = 1'b0;
            done_d    = 1'b1;
            gap_cnt_d = {GW{1'b0}};
          end else begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            sdi_d   = shift_q[FRAME_BITS-2];
          end
        end else begin
          state_d = SHIFT;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sdi_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops straight back to an idle bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 5'd0;
      gap_cnt_q    <= {GW{1'b0}};
      shift_q      <= {FRAME_BITS{1'b0}};
      sdi_q        <= 1'b0;
      cs_q         <= 1'b1;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      hold_empty_q <= 1'b1;
      hold_data_q  <= {DATA_BITS{1'b0}};
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shift_q      <= shift_d;
      sdi_q        <= sdi_d;
      cs_q         <= cs_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      hold_empty_q <= hold_empty_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule

// File: tb/tb_dac_write_12bit.sv
// tb_dac_write_12bit: bench for the DAC SPI writer. Instance 0 uses the
// default timing, instance 1 uses CLK_DIV=4 / CS_GAP=5. A bus monitor decodes
// each frame from CS/SCK/SDI as a DAC would; expectations come from the frame
// layout and the edge timing formulas. Honours DAC_PD_CTRL_EN when defined.
module tb_dac_write_12bit;

`ifdef DAC_PD_CTRL_EN
  localparam bit PD_CTRL = 1'b1;
`else
  localparam bit PD_CTRL = 1'b0;
`endif

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n   [2];
  logic [11:0] din     [2];
  logic        dv      [2];
  logic [1:0]  pd      [2];
  logic        ready_w [2];
  logic        cs_w    [2];
  logic        sck_w   [2];
  logic        sdi_w   [2];
  logic        busy_w  [2];
  logic        done_w  [2];

  int n_checks = 0;
  int n_fail   = 0;

  dac_write_12bit u_dut0 (
    .clk       (clk),
    .rst       (rst_n[0]),
    .data_in   (din[0]),
    .data_valid(dv[0]),
    .data_ready(ready_w[0]),
`ifdef DAC_PD_CTRL_EN
    .pd_mode   (pd[0]),
`endif
    .CS        (cs_w[0]),
    .SCK       (sck_w[0]),
    .SDI       (sdi_w[0]),
    .busy      (busy_w[0]),
    .frame_done(done_w[0])
  );

  dac_write_12bit #(.CLK_DIV(4), .CS_GAP(5)) u_dut1 (
    .clk       (clk),
    .rst       (rst_n[1]),
    .data_in   (din[1]),
    .data_valid(dv[1]),
    .data_ready(ready_w[1]),
`ifdef DAC_PD_CTRL_EN
    .pd_mode   (pd[1]),
`endif
    .CS        (cs_w[1]),
    .SCK       (sck_w[1]),
    .SDI       (sdi_w[1]),
    .busy      (busy_w[1]),
    .frame_done(done_w[1])
  );

  // Reference frame: 00, pd (only when the feature exists), 12-bit sample.
  function automatic int exp_frame(input logic [1:0] p, input logic [11:0] d);
    return (PD_CTRL ? int'(p) : 0) * 4096 + int'(d);
  endfunction

  // Cycle index of the most recent rising clk edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor state, one slot per instance.
  logic        prev_cs     [2] = '{1'b1, 1'b1};
  logic        prev_sck    [2] = '{1'b1, 1'b1};
  logic [15:0] shreg       [2] = '{16'h0, 16'h0};
  logic [15:0] last_frame  [2] = '{16'h0, 16'h0};
  logic [15:0] prev_frame  [2] = '{16'h0, 16'h0};
  int          nbits       [2] = '{0, 0};
  int          fall_cyc    [2] = '{0, 0};
  int          rise_cyc    [2] = '{0, 0};
  int          first_fall  [2] = '{-1, -1};
  int          last_fall   [2] = '{0, 0};
  int          min_per     [2] = '{0, 0};
  int          max_per     [2] = '{0, 0};
  int          last_nbits  [2] = '{0, 0};
  int          last_cs_low [2] = '{0, 0};
  int          last_gap    [2] = '{0, 0};
  int          frames_cnt  [2] = '{0, 0};
  int          done_cnt    [2] = '{0, 0};
  int          done_cyc    [2] = '{0, 0};

  // Decode the SPI bus as the DAC sees it: sample SDI on every SCK fall
  // while CS is low, close the frame when CS returns high.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (prev_cs[i] === 1'b1 && cs_w[i] === 1'b0) begin
        fall_cyc[i]   <= cyc;
        shreg[i]      <= 16'h0;
        nbits[i]      <= 0;
        first_fall[i] <= -1;
        min_per[i]    <= 1000000;
        max_per[i]    <= 0;
        last_gap[i]   <= cyc - rise_cyc[i];
      end else if (cs_w[i] === 1'b0 && prev_sck[i] === 1'b1 && sck_w[i] === 1'b0) begin
        shreg[i] <= {shreg[i][14:0], sdi_w[i]};
        nbits[i] <= nbits[i] + 1;
        if (first_fall[i] < 0) begin
          first_fall[i] <= cyc;
        end else begin
          if (cyc - last_fall[i] < min_per[i]) min_per[i] <= cyc - last_fall[i];
          if (cyc - last_fall[i] > max_per[i]) max_per[i] <= cyc - last_fall[i];
        end
        last_fall[i] <= cyc;
      end else if (prev_cs[i] === 1'b0 && cs_w[i] === 1'b1) begin
        rise_cyc[i]    <= cyc;
        prev_frame[i]  <= last_frame[i];
        last_frame[i]  <= shreg[i];
        last_nbits[i]  <= nbits[i];
        last_cs_low[i] <= cyc - fall_cyc[i];
        frames_cnt[i]  <= frames_cnt[i] + 1;
      end
      if (done_w[i] === 1'b1) begin
        done_cnt[i] <= done_cnt[i] + 1;
        done_cyc[i] <= cyc;
      end
      prev_cs[i]  <= cs_w[i];
      prev_sck[i] <= sck_w[i];
    end
  end

  // One stimulus step: just after the falling clk edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Offer one word and return the clk edge on which it was accepted.
  task automatic send_one(input int d, input logic [11:0] w, input logic [1:0] p, output int acc);
    int b;
    b = 400;
    while (ready_w[d] !== 1'b1 && b > 0) begin
      step();
      b--;
    end
    if (b == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout dut%0d: data_ready=%b, required 1", d, ready_w[d]);
    end
    din[d] = w;
    pd[d]  = p;
    dv[d]  = 1'b1;
    step();
    acc   = cyc;
    dv[d] = 1'b0;
  endtask

  // Wait (bounded) until the monitor has closed the given number of frames.
  task automatic wait_frames(input int d, input int target);
    int b;
    b = 3000;
    while (frames_cnt[d] < target && b > 0) begin
      step();
      b--;
    end
    if (frames_cnt[d] < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout dut%0d: frames %0d, required %0d", d, frames_cnt[d], target);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
      end
      step();
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if ({cs_w[i], sck_w[i], sdi_w[i], ready_w[i], busy_w[i], done_w[i]} !== 6'b110100) begin
          n_fail++;
          $display("FAIL reset_state dut%0d step %0d: {CS,SCK,SDI,ready,busy,done}=%b, required 110100",
                   i, k, {cs_w[i], sck_w[i], sdi_w[i], ready_w[i], busy_w[i], done_w[i]});
        end
      end
    end
  endtask

  task automatic test_single();
    logic [11:0] w;
    logic [1:0]  p;
    int acc, dc, fc;
    for (int k = 0; k < 4; k++) begin
      w  = (k == 0) ? 12'hA5C : 12'($urandom_range(0, 4095));
      p  = 2'($urandom_range(0, 3));
      dc = done_cnt[0];
      fc = frames_cnt[0];
      send_one(0, w, p, acc);
      n_checks++;
      if (ready_w[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_after_accept: data_ready=%b, required 0", ready_w[0]);
      end
      step();
      step();
      n_checks++;
      if (busy_w[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_in_frame: busy=%b, required 1", busy_w[0]);
      end
      wait_frames(0, fc + 1);
      repeat (8) step();
      n_checks++;
      if (fall_cyc[0] !== acc + 1) begin
        n_fail++;
        $display("FAIL cs_fall_time: cycle %0d, required %0d", fall_cyc[0], acc + 1);
      end
      n_checks++;
      if (first_fall[0] !== acc + 2 || last_fall[0] !== acc + 32) begin
        n_fail++;
        $display("FAIL sck_fall_times: first %0d last %0d, required %0d and %0d",
                 first_fall[0], last_fall[0], acc + 2, acc + 32);
      end
      n_checks++;
      if (rise_cyc[0] !== acc + 33 || last_cs_low[0] !== 32) begin
        n_fail++;
        $display("FAIL cs_low: rise at %0d low for %0d, required %0d and 32",
                 rise_cyc[0], last_cs_low[0], acc + 33);
      end
      n_checks++;
      if (last_nbits[0] !== 16 || int'(last_frame[0]) !== exp_frame(p, w)) begin
        n_fail++;
        $display("FAIL frame_single: %0d bits value %h, required 16 bits value %h",
                 last_nbits[0], last_frame[0], exp_frame(p, w));
      end
      n_checks++;
      if (min_per[0] !== 2 || max_per[0] !== 2) begin
        n_fail++;
        $display("FAIL sck_period: min %0d max %0d, required 2", min_per[0], max_per[0]);
      end
      n_checks++;
      if (done_cnt[0] !== dc + 1 || done_cyc[0] !== rise_cyc[0]) begin
        n_fail++;
        $display("FAIL frame_done_single: pulses %0d at %0d, required %0d at %0d",
                 done_cnt[0] - dc, done_cyc[0], 1, rise_cyc[0]);
      end
      n_checks++;
      if (busy_w[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_idle: busy=%b, required 0", busy_w[0]);
      end
    end
  endtask

  // Hold data_valid across two words; the second is offered while the
  // first one is still waiting or shifting.
  task automatic run_pair(input int d, input int h, input int g,
                          input logic [11:0] w1, input logic [11:0] w2,
                          input logic [1:0] p1, input logic [1:0] p2);
    int acc1, acc2, fc, dc, b, r1;
    fc = frames_cnt[d];
    dc = done_cnt[d];
    b  = 400;
    while (ready_w[d] !== 1'b1 && b > 0) begin
      step();
      b--;
    end
    din[d] = w1;
    pd[d]  = p1;
    dv[d]  = 1'b1;
    step();
    acc1   = cyc;
    din[d] = w2;
    pd[d]  = p2;
    b      = 400;
    while (ready_w[d] !== 1'b1 && b > 0) begin
      step();
      b--;
    end
    step();
    acc2  = cyc;
    dv[d] = 1'b0;
    wait_frames(d, fc + 2);
    repeat (40) step();
    r1 = fall_cyc[d] - last_gap[d];
    n_checks++;
    if (frames_cnt[d] !== fc + 2 || done_cnt[d] !== dc + 2) begin
      n_fail++;
      $display("FAIL pair_count dut%0d: frames %0d done %0d, required 2 and 2",
               d, frames_cnt[d] - fc, done_cnt[d] - dc);
    end
    n_checks++;
    if (int'(prev_frame[d]) !== exp_frame(p1, w1) || int'(last_frame[d]) !== exp_frame(p2, w2)) begin
      n_fail++;
      $display("FAIL pair_frames dut%0d: %h then %h, required %h then %h",
               d, prev_frame[d], last_frame[d], exp_frame(p1, w1), exp_frame(p2, w2));
    end
    n_checks++;
    if (!(acc2 > acc1 && acc2 < r1)) begin
      n_fail++;
      $display("FAIL double_buffer dut%0d: second accept at %0d, required between %0d and %0d",
               d, acc2, acc1, r1);
    end
    n_checks++;
    if ((d == 0) ? (last_gap[d] !== g) : (last_gap[d] < g)) begin
      n_fail++;
      $display("FAIL cs_gap dut%0d: CS high %0d cycles, required %0d", d, last_gap[d], g);
    end
    n_checks++;
    if (last_cs_low[d] !== 32 * h || min_per[d] !== 2 * h || max_per[d] !== 2 * h) begin
      n_fail++;
      $display("FAIL pair_timing dut%0d: CS low %0d period %0d..%0d, required %0d and %0d",
               d, last_cs_low[d], min_per[d], max_per[d], 32 * h, 2 * h);
    end
  endtask

  task automatic test_back_to_back();
    run_pair(0, 1, 2, 12'h001, 12'hFFF, 2'b00, 2'b00);
    run_pair(0, 1, 2, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
  endtask

  task automatic test_params();
    for (int k = 0; k < 2; k++) begin
      run_pair(1, 4, 5, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_midframe();
    int acc, dc, fc, b;
    logic [1:0] p;
    send_one(0, 12'($urandom_range(0, 4095)), 2'b00, acc);
    b = 400;
    while (!(cs_w[0] === 1'b0 && nbits[0] == 10) && b > 0) begin
      step();
      b--;
    end
    if (b == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL midframe_wait: nbits=%0d, required 10", nbits[0]);
    end
    dc = done_cnt[0];
    rst_n[0] = 1'b0;
    #1;
    n_checks++;
    if ({cs_w[0], sck_w[0], sdi_w[0], ready_w[0], busy_w[0]} !== 5'b11010) begin
      n_fail++;
      $display("FAIL async_reset: {CS,SCK,SDI,ready,busy}=%b, required 11010",
               {cs_w[0], sck_w[0], sdi_w[0], ready_w[0], busy_w[0]});
    end
    repeat (3) step();
    rst_n[0] = 1'b1;
    repeat (6) step();
    n_checks++;
    if (done_cnt[0] !== dc || cs_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_no_done: pulses %0d CS=%b, required 0 and 1", done_cnt[0] - dc, cs_w[0]);
    end
    fc = frames_cnt[0];
    p  = 2'($urandom_range(0, 3));
    send_one(0, 12'h3C3, p, acc);
    wait_frames(0, fc + 1);
    repeat (6) step();
    n_checks++;
    if (last_nbits[0] !== 16 || int'(last_frame[0]) !== exp_frame(p, 12'h3C3) || done_cnt[0] !== dc + 1) begin
      n_fail++;
      $display("FAIL after_reset_frame: %0d bits %h pulses %0d, required 16 bits %h pulses 1",
               last_nbits[0], last_frame[0], done_cnt[0] - dc, exp_frame(p, 12'h3C3));
    end
  endtask

  task automatic test_pd_field();
    logic [11:0] w;
    logic [1:0]  p;
    int acc, fc;
    for (int k = 0; k < 3; k++) begin
      w  = (k == 0) ? 12'h123 : 12'($urandom_range(0, 4095));
      p  = (k == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      fc = frames_cnt[0];
      send_one(0, w, p, acc);
      wait_frames(0, fc + 1);
      repeat (4) step();
      n_checks++;
      if (int'(last_frame[0]) !== exp_frame(p, w)) begin
        n_fail++;
        $display("FAIL pd_frame: pd=%b data=%h gave %h, required %h", p, w, last_frame[0], exp_frame(p, w));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      din[i]   = 12'h000;
      dv[i]    = 1'b0;
      pd[i]    = 2'b00;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_midframe();
    test_params();
    test_pd_field();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
